// File: rtl/display_scan_7seg.sv
// display_scan_7seg
//   Multiplexed 7-segment driver. It takes a WIDTH-bit unsigned value and
//   shows it in decimal on DIGITS digits. Binary-to-BCD conversion is
//   sequential: shift-add-3, one bit per clock, behind a valid/ready
//   handshake. A prescaled scan counter time-multiplexes the digits.
//
//   Ports
//     clock    system clock, rising edge
//     reset_n  asynchronous active-low reset
//     numero   value to display, sampled only when valid && ready
//     valid    load request
//     ready    1 = idle, the next valid is accepted
//     ovf      1 = last loaded value needs more than DIGITS digits
//     display  [DIGITS+7:8] digit enables, active-low one-hot
//              [7:0]        segments {dp,g,f,e,d,c,b,a}, active-high
//
//   Build option
//     DISP7SEG_LZB_EN  leading-zero blanking. When it is defined, each
//                      upper digit that is zero, with all higher digits
//                      also zero, shows blank. Digit 0 is never blanked.

// Nibble to segment decoder. Codes 0-9 give decimal glyphs.
// Every other code, including the blank code 4'hF, turns all segments off.
module bin2sevenSeg (
    input  logic [3:0] bin,
    output logic [7:0] seg
);
    always_comb begin
        seg = 8'h00;
        case (bin)
            4'd0: seg = 8'h3F;
            4'd1: seg = 8'h06;
            4'd2: seg = 8'h5B;
            4'd3: seg = 8'h4F;
            4'd4: seg = 8'h66;
            4'd5: seg = 8'h6D;
            4'd6: seg = 8'h7D;
            4'd7: seg = 8'h07;
            4'd8: seg = 8'h7F;
            4'd9: seg = 8'h6F;
            default: seg = 8'h00;
        endcase
    end
endmodule

module display_scan_7seg #(
    parameter int WIDTH    = 8,
    parameter int DIGITS   = 4,
    parameter int SCAN_DIV = 50000
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [WIDTH-1:0]  numero,
    input  logic              valid,
    output logic              ready,
    output logic              ovf,
    output logic [DIGITS+7:0] display
);
    // ceil(WIDTH/3) decimal nibbles hold any WIDTH-bit value (10^(1/3) > 2)
    localparam int NB = (WIDTH + 2) / 3;
    localparam int CW = $clog2(WIDTH + 1);
    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_LOAD} state_t;

    state_t                   state_q, state_d;
    logic [WIDTH-1:0]         sreg_q;
    logic [NB-1:0][3:0]       bcd_q, bcd_adj;
    logic [NB*4+WIDTH-1:0]    shifted;
    logic [CW-1:0]            cnt_q;
    logic [DIGITS-1:0][3:0]   dig_q, dig_load, shown;
    logic                     ovf_q, ovf_load;
    logic [PW-1:0]            pre_q;
    logic [IW-1:0]            idx_q;
    logic [DIGITS-1:0]        en;
    logic [7:0]               seg;

    // ---------------- conversion FSM ----------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (valid) state_d = S_SHIFT;
            S_SHIFT: if (cnt_q == CW'(WIDTH - 1)) state_d = S_LOAD;
            S_LOAD:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign ready = (state_q == S_IDLE);

    // Add 3 before the shift, so a nibble >= 5 carries into the next decade.
    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < NB; i++)
            if (bcd_q[i] >= 4'd5) bcd_adj[i] = bcd_q[i] + 4'd3;
    end
    assign shifted = {bcd_adj, sreg_q} << 1;

    // Digits beyond the BCD width read as 0. BCD nibbles beyond DIGITS set ovf.
    for (genvar i = 0; i < DIGITS; i++) begin : g_dig
        if (i < NB) begin : g_bcd
            assign dig_load[i] = bcd_q[i];
        end else begin : g_zero
            assign dig_load[i] = 4'd0;
        end
    end
    if (NB > DIGITS) begin : g_ovf
        assign ovf_load = |bcd_q[NB-1:DIGITS];
    end else begin : g_no_ovf
        assign ovf_load = 1'b0;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sreg_q <= '0;
            bcd_q  <= '0;
            cnt_q  <= '0;
            dig_q  <= '0;
            ovf_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: if (valid) begin
                    sreg_q <= numero;
                    bcd_q  <= '0;
                    cnt_q  <= '0;
                end
                S_SHIFT: begin
                    {bcd_q, sreg_q} <= shifted;
                    cnt_q           <= cnt_q + 1'b1;
                end
                S_LOAD: begin
                    dig_q <= dig_load;
                    ovf_q <= ovf_load;
                end
                default: ;
            endcase
        end
    end

    assign ovf = ovf_q;

    // ---------------- digit scan ----------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pre_q <= '0;
            idx_q <= '0;
        end else if (pre_q == PW'(SCAN_DIV - 1)) begin
            pre_q <= '0;
            idx_q <= (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
        end else begin
            pre_q <= pre_q + 1'b1;
        end
    end

`ifdef DISP7SEG_LZB_EN
    // Walk from the top digit down. lead stays set while every digit so far is zero.
    logic lead;
    always_comb begin
        shown = dig_q;
        lead  = 1'b1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            lead = lead & (dig_q[i] == 4'd0);
            if (i != 0 && lead) shown[i] = 4'hF;
        end
    end
`else
    assign shown = dig_q;
`endif

    always_comb begin
        en = '1;
        for (int i = 0; i < DIGITS; i++)
            if (idx_q == IW'(i)) en[i] = 1'b0;
    end

    bin2sevenSeg u_seg (
        .bin (shown[idx_q]),
        .seg (seg)
    );

    assign display = {en, seg};
endmodule
